log_result_combiner: RTL and testbench
======================================

# log_result_combiner

Output stage of the hyperbolic-CORDIC logarithm datapath. It receives the CORDIC mantissa result ln(m) together with the matching exponent field, which arrives already aligned through the 19-cycle exponent delay line, and computes ln(x) = ln(m) + (E − 127)·ln2 in a 3-stage pipeline. Results go into a small output FIFO so a downstream consumer with a valid/ready handshake can drain a free-running producer.

## Interface
- DATA_W, default 32: signed fixed-point width of ln(m) input and ln(x) output.
- FRAC_W, default 20: fractional bits of both input and output.
- FIFO_DEPTH, default 4: output FIFO entries, power of two ≥ 2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ln(m) and exponent valid this cycle; no backpressure upstream.
- lnm_in  in  DATA_W  signed ln(m), Q(DATA_W−FRAC_W−1).FRAC_W.
- exponent_in  in  8  biased exponent, delay-aligned with lnm_in.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry when out_valid=1.
- out_data  out  DATA_W  signed ln(x), same Q format.
- out_flags  out  2  head entry flags: bit0 zero/denormal input, bit1 inf/NaN input.
- overflow  out  1  sticky: a result was dropped because the FIFO was full.

## Operation
- S1, capture: register lnm, k = exponent_in − 127 as 9-bit signed (range −127..128), and in_valid. Special-case flags are decoded here.
- S2, scale: p = k · LN2_Q, with LN2_Q = 726817 (round(ln2·2^20), FRAC_W=20). The product is 30 bits signed and sign-extended to DATA_W+1.
- S3, sum: s = lnm + p in DATA_W+1 bits, saturated to the signed DATA_W range.
- S3 write: if valid, the result is written to the FIFO. If the FIFO is full and no pop happens in the same cycle, the result is dropped and overflow is set.
- The pipeline is free-running. Invalid slots advance but never write.
- FIFO pop: occurs when out_valid && out_ready. Push and pop in the same cycle are always legal, including when the FIFO is full (no drop) and when it is empty (an empty FIFO does not pop, so the push lands and out_valid rises next cycle).
- out_data and out_flags come from registered FIFO head storage. They are stable while out_valid=1 and out_ready=0.
- overflow stays high until reset.
- Reset mid-operation: all pipeline valids, FIFO pointers and overflow clear immediately. In-flight results are discarded.

## Timing
- Reset values: out_valid=0, out_data=0, out_flags=0, overflow=0. All internal valids are 0.
- Latency: an input sampled at edge N appears with out_valid=1 after edge N+3 when the FIFO is empty.
- Throughput: one result per cycle when out_ready is held high.
- The first input after reset release is sampled on the first rising edge with rst_n=1.

## Configuration
- LOG_SPECIAL_CASE_EN defined:
  - exponent_in=0 sets flag bit0 and forces the result to the most negative value (0x80000000).
  - exponent_in=255 sets flag bit1 and forces the result to the most positive value (0x7FFFFFFF).
  - Flags travel with the data through S2/S3 and the FIFO.
- LOG_SPECIAL_CASE_EN undefined:
  - No decode; out_flags is tied to 0.
  - Exponents 0 and 255 go through normal arithmetic (k = −127, k = 128).

## Structure
- Package log_pkg holds EXP_BIAS=127, LN2_Q, the flag bit indices, and a typedef for the packed FIFO entry {flags, data}.
- One sub-module, log_out_fifo: parametric synchronous FIFO with push, pop, full, empty and registered head output. The combiner instantiates it once.

## Test plan
- Basic values, out_ready=1, macro defined:
  - exponent 127, lnm 0 → out_data 0.
  - exponent 128, lnm 0 → out_data 726817.
  - exponent 126, lnm 363409 → out_data −363408. Each appears 3 cycles after input.
- Back-to-back inputs for 10 cycles with out_ready=1 → 10 results in order on consecutive cycles, overflow=0.
- out_ready=0, then 6 consecutive valid inputs → FIFO holds the first 4, overflow=1. Raise out_ready → exactly 4 pops, in original order.
- FIFO full, then push and pop in the same cycle → no drop, overflow stays 0, occupancy stays 4.
- Special cases with the macro defined:
  - exponent 0 → out_data 0x80000000, out_flags 01.
  - exponent 255 → out_data 0x7FFFFFFF, out_flags 10.
  - Without the macro, exponent 0 with lnm 0 → −92305759, flags 00.
- Assert rst_n=0 while 2 results are in the pipeline and 3 are in the FIFO → out_valid=0 and overflow=0 immediately; no stale output after rst_n rises.

Source files
------------

// File: rtl/log_pkg.sv
// log_pkg: shared constants, flag indices and FIFO entry type for the log result combiner
package log_pkg;
    localparam int EXP_BIAS     = 127;
    localparam int LN2_Q        = 726817;
    localparam int LN2_FRAC     = 20;
    localparam int FLAG_ZERO    = 0;
    localparam int FLAG_INF     = 1;
    localparam int ENTRY_DATA_W = 32;
    typedef struct packed {
        logic [1:0]              flags;
        logic [ENTRY_DATA_W-1:0] data;
    } log_entry_t;
endpackage

// File: rtl/log_out_fifo.sv
// log_out_fifo: synchronous FIFO with push/pop, full/empty and a head output taken from registered storage
module log_out_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;
    assign empty     = count == '0;
    assign full      = count == (AW+1)'(DEPTH);
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr];
    // pointers and occupancy; a pop frees a slot for a push in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    // entry storage
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/log_result_combiner.sv
// log_result_combiner: ln(x) = ln(m) + (E-127)*ln2 in a 3-stage pipeline feeding an output FIFO; LOG_SPECIAL_CASE_EN enables zero/inf decode
module log_result_combiner
    import log_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FRAC_W     = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] lnm_in,
    input  logic [7:0]        exponent_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_flags,
    output logic              overflow
);
    localparam logic signed [DATA_W:0] LN2 = (DATA_W+1)'((longint'(LN2_Q) << FRAC_W) >>> LN2_FRAC);
    localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};
    logic                   v1, v2, v3;
    logic [DATA_W-1:0]      lnm1, lnm2, d3, sum_sat, res;
    logic signed [8:0]      k1;
    logic signed [DATA_W:0] prod, p2;
    logic [DATA_W:0]        s;
    logic [1:0]             f1, f2, f3;
    logic [DATA_W+1:0]      head;
    logic                   full, empty, pop;
    assign prod      = (DATA_W+1)'(k1) * LN2;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign out_data  = head[DATA_W-1:0];
    assign out_flags = head[DATA_W+1:DATA_W];
    // S3 sum with saturation, then special exponents override the value
    always_comb begin
        s       = {lnm2[DATA_W-1], lnm2} + p2;
        sum_sat = (s[DATA_W] != s[DATA_W-1]) ? (s[DATA_W] ? MIN_V : MAX_V) : s[DATA_W-1:0];
        res     = f2[FLAG_ZERO] ? MIN_V : f2[FLAG_INF] ? MAX_V : sum_sat;
    end
    // datapath stages; only the valids need reset since invalid slots never write
    always_ff @(posedge clk) begin
        lnm1 <= lnm_in;
        k1   <= $signed({1'b0, exponent_in} - 9'(EXP_BIAS));
`ifdef LOG_SPECIAL_CASE_EN
        f1[FLAG_ZERO] <= exponent_in == 8'h00;
        f1[FLAG_INF]  <= exponent_in == 8'hff;
`else
        f1 <= '0;
`endif
        lnm2 <= lnm1;
        p2   <= prod;
        f2   <= f1;
        d3   <= res;
        f3   <= f2;
    end
    // stage valids and sticky overflow on a dropped result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            overflow <= 1'b0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (v3 && full && !pop) overflow <= 1'b1;
        end
    end
    log_out_fifo #(.WIDTH(DATA_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (v3),
        .push_data ({f3, d3}),
        .pop       (pop),
        .head_data (head),
        .full      (full),
        .empty     (empty)
    );
endmodule

// File: tb/tb_log_result_combiner.sv
// tb_log_result_combiner: directed and random stimulus against a queue-based reference model
module tb_log_result_combiner;
    import log_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] lnm_in = '0;
    logic [7:0]  exponent_in = '0;
    logic        out_ready = 1'b0;
    logic        out_valid, overflow;
    logic [31:0] out_data;
    logic [1:0]  out_flags;
    int          passed = 0;
    int          total = 0;
    log_entry_t  mq[$];
    log_entry_t  se[3];
    bit          sv[3];
    bit          m_ovf = 1'b0;

    log_result_combiner dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .lnm_in      (lnm_in),
        .exponent_in (exponent_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_flags   (out_flags),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic log_entry_t model(input logic [31:0] lnm, input logic [7:0] e);
        longint s;
        log_entry_t r;
        s = longint'($signed(lnm)) + (longint'(e) - 127) * 726817;
        r.flags = 2'b00;
        r.data = s > 64'sd2147483647 ? 32'h7fffffff : s < -64'sd2147483648 ? 32'h80000000 : 32'(s);
`ifdef LOG_SPECIAL_CASE_EN
        if (e == 8'd0) r = '{2'b01, 32'h80000000};
        else if (e == 8'd255) r = '{2'b10, 32'h7fffffff};
`endif
        return r;
    endfunction

    task automatic step();
        bit         pop, wv;
        log_entry_t w;
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_flags", 32'(out_flags), 32'(mq[0].flags));
        end
        pop = out_ready && mq.size() != 0;
        wv = sv[2];
        w = se[2];
        sv[2] = sv[1]; se[2] = se[1];
        sv[1] = sv[0]; se[1] = se[0];
        sv[0] = in_valid; se[0] = model(lnm_in, exponent_in);
        if (pop) void'(mq.pop_front());
        if (wv) begin
            if (mq.size() < 4) mq.push_back(w);
            else m_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic drive(input bit v, input logic [31:0] lnm, input logic [7:0] e);
        in_valid = v;
        lnm_in = lnm;
        exponent_in = e;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 8'($urandom_range(0, 255)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst out_data", out_data, 32'd0);
        chk("rst out_flags", 32'(out_flags), 32'd0);
        mq.delete();
        sv = '{default: 1'b0};
        m_ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain_count(input string tag, input int want);
        int pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pops += int'(out_valid);
            idle(1);
        end
        chk(tag, 32'(pops), 32'(want));
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();
        // basic values with 3-cycle latency
        out_ready = 1'b1;
        drive(1'b1, 32'd0, 8'd127);
        idle(3);
        chk("e127 valid", 32'(out_valid), 32'd1);
        chk("e127 data", out_data, 32'd0);
        drive(1'b1, 32'd0, 8'd128);
        idle(3);
        chk("e128 data", out_data, 32'd726817);
        drive(1'b1, 32'd363409, 8'd126);
        idle(3);
        chk("e126 data", out_data, 32'(-363408));
`ifdef LOG_SPECIAL_CASE_EN
        drive(1'b1, 32'd12345, 8'd0);
        idle(3);
        chk("e0 data", out_data, 32'h80000000);
        chk("e0 flags", 32'(out_flags), 32'd1);
        drive(1'b1, 32'd12345, 8'd255);
        idle(3);
        chk("e255 data", out_data, 32'h7fffffff);
        chk("e255 flags", 32'(out_flags), 32'd2);
`else
        drive(1'b1, 32'd0, 8'd0);
        idle(3);
        chk("e0 data", out_data, 32'(-92305759));
        chk("e0 flags", 32'(out_flags), 32'd0);
`endif
        // saturation corners
        drive(1'b1, 32'h7ffffff0, 8'd200);
        drive(1'b1, 32'h80000010, 8'd10);
        idle(4);
        // back-to-back stream
        for (int i = 0; i < 10; i++) drive(1'b1, $urandom, 8'($urandom_range(1, 254)));
        idle(4);
        chk("stream overflow", 32'(overflow), 32'd0);
        // fill with stalled consumer, drop two
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b1, $urandom, 8'($urandom_range(0, 255)));
        idle(3);
        chk("drop overflow", 32'(overflow), 32'd1);
        drain_count("drop pops", 4);
        // full FIFO with simultaneous push and pop
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b1, $urandom, 8'($urandom_range(0, 255)));
        idle(2);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(2);
        chk("pushpop overflow", 32'(overflow), 32'd0);
        drain_count("pushpop pops", 4);
        // reset with results in flight and queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, 8'($urandom_range(0, 255)));
        idle(3);
        drive(1'b1, $urandom, 8'd130);
        drive(1'b1, $urandom, 8'd131);
        do_reset();
        out_ready = 1'b1;
        idle(6);
        // random traffic
        for (int i = 0; i < 300; i++) begin
            out_ready = 1'($urandom_range(0, 3) != 0);
            drive(1'($urandom_range(0, 2) != 0), $urandom, 8'($urandom_range(0, 255)));
        end
        out_ready = 1'b1;
        idle(8);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
